// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU I/D request ports and shared memory port bundle
// slave is the arbiter's view; master is the view of the CPU plus memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;

  logic              M_READ;
  logic              M_WRITE;
  logic [ADDR_W-1:0] M_ADDRESS;
  logic [DATA_W-1:0] M_WRITEDATA;
  logic [DATA_W-1:0] M_READDATA;
  logic              M_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS,
    output I_READDATA, I_BUSYWAIT,
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    output D_READDATA, D_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
    input  M_READDATA, M_BUSYWAIT
  );

  modport master (
    output I_READ, I_ADDRESS,
    input  I_READDATA, I_BUSYWAIT,
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    input  D_READDATA, D_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
    output M_READDATA, M_BUSYWAIT
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-to-one I/D arbiter in front of a single-port word memory
// D side has priority; a saturating starvation counter forces an I grant after MAX_WAIT losses.
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input logic               CLK,
  input logic               RESET,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, REL_I, REL_D} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t            state_q;
  logic              m_read_q;
  logic              m_write_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [3:0]        starve_q;
  logic [3:0]        starve_d;

  logic req_i;
  logic req_d;
  logic win_i;
  logic win_d;

  assign req_i = bus.I_READ;
  assign req_d = bus.D_READ | bus.D_WRITE;

  always_comb begin
    win_i    = req_i & (~req_d | (starve_q == MAX_W));
    win_d    = req_d & ~win_i;
    starve_d = starve_q;
    if (win_i) begin
      starve_d = '0;
    end else if (req_i && (starve_q < MAX_W)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Strobes and address/data are latched at the decision edge and held through GNT_x.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i || req_d) begin
            starve_q <= starve_d;
          end
          if (win_d) begin
            m_read_q  <= ~bus.D_WRITE;
            m_write_q <= bus.D_WRITE;
            m_addr_q  <= bus.D_ADDRESS;
            m_wdata_q <= bus.D_WRITEDATA;
            state_q   <= GNT_D;
          end else if (win_i) begin
            m_read_q  <= 1'b1;
            m_write_q <= 1'b0;
            m_addr_q  <= bus.I_ADDRESS;
            state_q   <= GNT_I;
          end
        end
        GNT_I: begin
          if (!bus.M_BUSYWAIT) begin
            i_rdata_q <= bus.M_READDATA;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            state_q   <= REL_I;
          end
        end
        GNT_D: begin
          if (!bus.M_BUSYWAIT) begin
            if (m_read_q) begin
              d_rdata_q <= bus.M_READDATA;
            end
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            state_q   <= REL_D;
          end
        end
        REL_I, REL_D: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.M_READ      = m_read_q;
  assign bus.M_WRITE     = m_write_q;
  assign bus.M_ADDRESS   = m_addr_q;
  assign bus.M_WRITEDATA = m_wdata_q;
  assign bus.I_READDATA  = i_rdata_q;
  assign bus.D_READDATA  = d_rdata_q;
  // Release is visible only in REL_x, so a requester is stalled the cycle it asks.
  assign bus.I_BUSYWAIT  = req_i & (state_q != REL_I);
  assign bus.D_BUSYWAIT  = req_d & (state_q != REL_D);

endmodule
